alu_request_arbiter: RTL and testbench



---
 rtl/alu_request_arbiter.sv | 166 ++++++++++++++++
 tb/tb_alu_request_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_request_arbiter.sv
// ----------------------------------------------------------------------------
// alu_request_arbiter
//
// Shares one combinational ALU (8-bit result) between two requesters.
// Requests are granted round-robin. The granted command is driven onto the
// ALU operand/opcode ports and held for SETTLE_CYCLES cycles. The ALU result
// is then captured and returned on a valid/ready response channel, tagged
// with the ID of the requester. Only one command is in flight at a time.
//
// Parameters
//   SETTLE_CYCLES  cycles operands are held on the ALU before capture (>=1)
//   CNT_WIDTH      width of the completed-operation counter
//
// Ports
//   clk, resetn                 clock (rising edge), async active-low reset
//   reqN_valid/op/a/b           requester N command (N = 0, 1)
//   reqN_ready                  requester N command accepted this cycle
//   alu_op/alu_a/alu_b          command driven to the shared ALU
//   alu_result                  combinational ALU output
//   rsp_valid/rsp_ready         response handshake
//   rsp_id                      requester that issued the command
//   rsp_data                    captured result (0 for illegal opcodes)
//   rsp_illegal                 opcode 6 or 7 was issued
//   op_count                    completed responses, wraps modulo 2^CNT_WIDTH
// ----------------------------------------------------------------------------
module alu_request_arbiter #(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 req0_valid,
    input  logic [2:0]           req0_op,
    input  logic [3:0]           req0_a,
    input  logic [3:0]           req0_b,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [2:0]           req1_op,
    input  logic [3:0]           req1_a,
    input  logic [3:0]           req1_b,
    output logic                 req1_ready,
    output logic [2:0]           alu_op,
    output logic [3:0]           alu_a,
    output logic [3:0]           alu_b,
    input  logic [7:0]           alu_result,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [7:0]           rsp_data,
    output logic                 rsp_illegal,
    output logic [CNT_WIDTH-1:0] op_count
);

    localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SC_W-1:0]      SC_LOAD = SC_W'(SETTLE_CYCLES - 1);
    localparam logic [SC_W-1:0]      SC_ONE  = SC_W'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [SC_W-1:0] r_cnt;
    logic            r_rr;
    logic            r_id;

    logic            w_gnt_any;
    logic            w_gnt_id;
    logic            w_cnt_zero;
    logic            w_illegal;

    assign w_gnt_any  = req0_valid | req1_valid;
    // With both requesters valid the round-robin pointer decides; otherwise
    // the single valid requester wins (req1_valid alone selects ID 1).
    assign w_gnt_id   = (req0_valid & req1_valid) ? r_rr : req1_valid;
    assign w_cnt_zero = (r_cnt == '0);
    // Opcodes 6 and 7 are the only ones with both upper bits set.
    assign w_illegal  = alu_op[2] & alu_op[1];

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_gnt_any)  w_next_state = S_SETTLE;
            S_SETTLE: if (w_cnt_zero) w_next_state = S_RESP;
            S_RESP:   if (rsp_ready)  w_next_state = S_IDLE;
            default:                  w_next_state = S_IDLE;
        endcase
    end

    // Output decode: ready only in IDLE toward the granted requester;
    // rsp_valid is a pure decode of the RESP state register.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                req0_ready = w_gnt_any & ~w_gnt_id;
                req1_ready = w_gnt_any &  w_gnt_id;
            end
            S_RESP:  rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Command latch, settle counter, response capture, counter and pointer.
    // alu_* only change on a grant, so they keep the last command otherwise.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            alu_op      <= 3'd0;
            alu_a       <= 4'd0;
            alu_b       <= 4'd0;
            r_id        <= 1'b0;
            r_cnt       <= '0;
            r_rr        <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_data    <= 8'd0;
            rsp_illegal <= 1'b0;
            op_count    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_any) begin
                        alu_op <= w_gnt_id ? req1_op : req0_op;
                        alu_a  <= w_gnt_id ? req1_a  : req0_a;
                        alu_b  <= w_gnt_id ? req1_b  : req0_b;
                        r_id   <= w_gnt_id;
                        r_cnt  <= SC_LOAD;
                    end
                end
                S_SETTLE: begin
                    if (w_cnt_zero) begin
                        rsp_data    <= w_illegal ? 8'd0 : alu_result;
                        rsp_illegal <= w_illegal;
                        rsp_id      <= r_id;
                    end else begin
                        r_cnt <= r_cnt - SC_ONE;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        op_count <= op_count + CNT_ONE;
                        // The requester just served loses priority next time.
                        r_rr     <= ~rsp_id;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_request_arbiter.sv
module tb_alu_request_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: SETTLE_CYCLES=1, CNT_WIDTH=2
    logic       resetn;
    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [2:0] req0_op, req1_op, alu_op;
    logic [3:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b;
    logic [7:0] alu_result, rsp_data;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_illegal;
    logic [1:0] op_count;

    // Second instance: SETTLE_CYCLES=4, CNT_WIDTH=8
    logic       b_resetn;
    logic       b_req0_valid, b_req1_valid, b_req0_ready, b_req1_ready;
    logic [2:0] b_req0_op, b_req1_op, b_alu_op;
    logic [3:0] b_req0_a, b_req0_b, b_req1_a, b_req1_b, b_alu_a, b_alu_b;
    logic [7:0] b_alu_result, b_rsp_data;
    logic       b_rsp_valid, b_rsp_ready, b_rsp_id, b_rsp_illegal;
    logic [7:0] b_op_count;

    alu_request_arbiter #(.SETTLE_CYCLES(1), .CNT_WIDTH(2)) dut (
        .clk(clk), .resetn(resetn),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_illegal(rsp_illegal), .op_count(op_count)
    );

    alu_request_arbiter #(.SETTLE_CYCLES(4), .CNT_WIDTH(8)) dut_s4 (
        .clk(clk), .resetn(b_resetn),
        .req0_valid(b_req0_valid), .req0_op(b_req0_op), .req0_a(b_req0_a), .req0_b(b_req0_b), .req0_ready(b_req0_ready),
        .req1_valid(b_req1_valid), .req1_op(b_req1_op), .req1_a(b_req1_a), .req1_b(b_req1_b), .req1_ready(b_req1_ready),
        .alu_op(b_alu_op), .alu_a(b_alu_a), .alu_b(b_alu_b), .alu_result(b_alu_result),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_id(b_rsp_id), .rsp_data(b_rsp_data),
        .rsp_illegal(b_rsp_illegal), .op_count(b_op_count)
    );

    // Environment ALU; illegal opcodes return a nonzero pattern on purpose.
    function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            3'd0:    alu_f = {3'b000, {1'b0, a} + 5'd1};
            3'd1:    alu_f = {3'b000, {1'b0, a} + {1'b0, b}};
            3'd2:    alu_f = {4'b0000, a + b};
            3'd3:    alu_f = {a | b, a ^ b};
            3'd4:    alu_f = {7'b0000000, |{a, b}};
            3'd5:    alu_f = {a, b};
            default: alu_f = 8'hA5;
        endcase
    endfunction

    assign alu_result   = alu_f(alu_op, alu_a, alu_b);
    assign b_alu_result = alu_f(b_alu_op, b_alu_a, b_alu_b);

    int nvec = 0;
    int nmis = 0;

    // Expected responses: {id, illegal, data}
    logic [9:0] exp_q[$];
    logic [9:0] b_q[$];
    logic [1:0] exp_cnt = 2'd0;
    logic [7:0] b_cnt   = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        nvec++;
        if (act !== expv) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Monitor for the main instance
    always @(negedge clk) begin
        logic [9:0] e;
        if (!resetn) begin
            exp_cnt = 2'd0;
        end else if (rsp_valid && rsp_ready) begin
            check("op_count", 32'(op_count), 32'(exp_cnt));
            exp_cnt = exp_cnt + 2'd1;
            if (exp_q.size() == 0) begin
                nvec++;
                nmis++;
                $display("FAIL unexpected_rsp: got id=%0d data=%0h, expected none", rsp_id, rsp_data);
            end else begin
                e = exp_q.pop_front();
                check("rsp_id",      32'(rsp_id),      32'(e[9]));
                check("rsp_illegal", 32'(rsp_illegal), 32'(e[8]));
                check("rsp_data",    32'(rsp_data),    32'(e[7:0]));
            end
        end
    end

    // Monitor for the SETTLE_CYCLES=4 instance
    always @(negedge clk) begin
        logic [9:0] e;
        if (!b_resetn) begin
            b_cnt = 8'd0;
        end else if (b_rsp_valid && b_rsp_ready) begin
            check("s4_op_count", 32'(b_op_count), 32'(b_cnt));
            b_cnt = b_cnt + 8'd1;
            if (b_q.size() == 0) begin
                nvec++;
                nmis++;
                $display("FAIL s4_unexpected_rsp: got id=%0d data=%0h, expected none", b_rsp_id, b_rsp_data);
            end else begin
                e = b_q.pop_front();
                check("s4_rsp_id",      32'(b_rsp_id),      32'(e[9]));
                check("s4_rsp_illegal", 32'(b_rsp_illegal), 32'(e[8]));
                check("s4_rsp_data",    32'(b_rsp_data),    32'(e[7:0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn     = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        repeat (2) tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic drive(input logic id, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] d, input logic ill);
        if (id == 1'b0) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end
        exp_q.push_back({id, ill, d});
    endtask

    task automatic wait_accept(input logic id);
        int  n    = 0;
        bit  seen = 1'b0;
        while (!seen && n < 50) begin
            @(negedge clk);
            if ((id == 1'b0) ? req0_ready : req1_ready) seen = 1'b1;
            else n++;
        end
        if (!seen) begin
            nvec++;
            nmis++;
            $display("FAIL accept_timeout: req%0d ready never seen, expected within 50 cycles", id);
        end
        tick();
        if (id == 1'b0) req0_valid = 1'b0;
        else            req1_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_one(input logic id, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                           input logic [7:0] d, input logic ill);
        drive(id, op, a, b, d, ill);
        wait_accept(id);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  seen;
        logic g;

        resetn = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b0; req0_op = 3'd0; req0_a = 4'd0; req0_b = 4'd0;
        req1_valid = 1'b0; req1_op = 3'd0; req1_a = 4'd0; req1_b = 4'd0;
        b_resetn = 1'b0; b_rsp_ready = 1'b1;
        b_req0_valid = 1'b0; b_req0_op = 3'd0; b_req0_a = 4'd0; b_req0_b = 4'd0;
        b_req1_valid = 1'b0; b_req1_op = 3'd0; b_req1_a = 4'd0; b_req1_b = 4'd0;

        do_reset();
        b_resetn = 1'b1;

        // Reset state
        check("rst_rsp_valid",   32'(rsp_valid),   32'd0);
        check("rst_rsp_data",    32'(rsp_data),    32'd0);
        check("rst_rsp_id",      32'(rsp_id),      32'd0);
        check("rst_rsp_illegal", 32'(rsp_illegal), 32'd0);
        check("rst_op_count",    32'(op_count),    32'd0);
        check("rst_alu_cmd",     32'({alu_op, alu_a, alu_b}), 32'd0);

        // Single issue with latency
        drive(1'b0, 3'd1, 4'h9, 4'h8, 8'h11, 1'b0);
        @(negedge clk);
        check("single_ready_pre", 32'(req0_ready), 32'd1);
        tick();
        @(negedge clk);
        check("single_ready_post", 32'(req0_ready), 32'd0);
        check("single_valid_early", 32'(rsp_valid), 32'd0);
        check("single_alu_cmd", 32'({alu_op, alu_a, alu_b}), 32'h198);
        tick();
        req0_valid = 1'b0;
        check("single_valid_lat", 32'(rsp_valid), 32'd1);
        drain();

        // Opcode coverage
        run_one(1'b0, 3'd0, 4'hF, 4'h0, 8'h10, 1'b0);
        run_one(1'b1, 3'd2, 4'h9, 4'h8, 8'h01, 1'b0);
        run_one(1'b0, 3'd3, 4'hC, 4'hA, 8'hE6, 1'b0);
        run_one(1'b1, 3'd4, 4'h0, 4'h0, 8'h00, 1'b0);
        run_one(1'b0, 3'd5, 4'h3, 4'h7, 8'h37, 1'b0);
        check("alu_hold_idle", 32'({alu_op, alu_a, alu_b}), 32'h537);

        // Fairness: both valid continuously after reset
        do_reset();
        exp_q.push_back({1'b0, 1'b0, 8'h12});
        exp_q.push_back({1'b1, 1'b0, 8'h34});
        exp_q.push_back({1'b0, 1'b0, 8'h12});
        exp_q.push_back({1'b1, 1'b0, 8'h34});
        req0_valid = 1'b1; req0_op = 3'd5; req0_a = 4'h1; req0_b = 4'h2;
        req1_valid = 1'b1; req1_op = 3'd5; req1_a = 4'h3; req1_b = 4'h4;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            seen = 1'b0;
            g = 1'b0;
            while (!seen && n < 50) begin
                @(negedge clk);
                if (req0_ready || req1_ready) begin
                    seen = 1'b1;
                    g = req1_ready;
                    check("grant_exclusive", 32'(req0_ready & req1_ready), 32'd0);
                end else begin
                    n++;
                end
            end
            check("grant_seen", 32'(seen), 32'd1);
            check("grant_order", 32'(g), 32'(k % 2));
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();

        // Backpressure
        rsp_ready = 1'b0;
        drive(1'b0, 3'd3, 4'hC, 4'hA, 8'hE6, 1'b0);
        wait_accept(1'b0);
        drive(1'b1, 3'd0, 4'hF, 4'h0, 8'h10, 1'b0);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid",  32'(rsp_valid), 32'd1);
            check("bp_data",   32'(rsp_data),  32'hE6);
            check("bp_id",     32'(rsp_id),    32'd0);
            check("bp_readys", 32'({req0_ready, req1_ready}), 32'd0);
            check("bp_count",  32'(op_count),  32'(exp_cnt));
        end
        tick();
        rsp_ready = 1'b1;
        wait_accept(1'b1);
        drain();

        // Illegal opcodes and counter wrap
        do_reset();
        run_one(1'b1, 3'd7, 4'h3, 4'h4, 8'h00, 1'b1);
        run_one(1'b0, 3'd6, 4'h5, 4'h6, 8'h00, 1'b1);
        run_one(1'b1, 3'd1, 4'h2, 4'h3, 8'h05, 1'b0);
        run_one(1'b0, 3'd5, 4'hA, 4'hB, 8'hAB, 1'b0);
        tick();
        check("op_count_wrap", 32'(op_count), 32'd0);

        // SETTLE_CYCLES=4: reset during SETTLE aborts the command
        b_req0_valid = 1'b1; b_req0_op = 3'd1; b_req0_a = 4'h1; b_req0_b = 4'h2;
        n = 0;
        while (!b_req0_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("s4_first_ready", 32'(b_req0_ready), 32'd1);
        tick();
        b_req0_valid = 1'b0;
        tick();
        check("s4_in_settle", 32'(b_alu_op), 32'd1);
        #2;
        b_resetn = 1'b0;
        #1;
        check("s4_rst_alu", 32'({b_alu_op, b_alu_a, b_alu_b}), 32'd0);
        check("s4_rst_rsp", 32'({b_rsp_valid, b_rsp_id, b_rsp_illegal, b_rsp_data}), 32'd0);
        check("s4_rst_cnt", 32'(b_op_count), 32'd0);
        repeat (2) tick();
        b_resetn = 1'b1;
        repeat (8) tick();
        check("s4_no_rsp", 32'(b_rsp_valid), 32'd0);

        // Next request served normally, with four-cycle latency
        b_q.push_back({1'b1, 1'b0, 8'hAB});
        b_req1_valid = 1'b1; b_req1_op = 3'd5; b_req1_a = 4'hA; b_req1_b = 4'hB;
        n = 0;
        while (!b_req1_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("s4_second_ready", 32'(b_req1_ready), 32'd1);
        tick();
        b_req1_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("s4_latency", 32'(b_rsp_valid), 32'(k == 4));
        end
        n = 0;
        while (b_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        check("s4_queue_drained", 32'(b_q.size()), 32'd0);
        check("queue_final", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
